dmem_stall_ctrl: RTL and testbench
==================================

DMEM_STALL_CTRL -- requirements
Module: dmem_stall_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles waiting for resp_valid before a bus error; legal range 1..1023.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port mem_read, input, 1, current memory-stage instruction is a load.
REQ-005 SHALL have port mem_write, input, 1, current memory-stage instruction is a store.
REQ-006 SHALL have port mem_size, input, 2, access size: 00 byte, 01 half, 10 word; 11 reserved, treated as word.
REQ-007 SHALL have port mem_unsigned, input, 1, zero-extend load data when high, sign-extend when low.
REQ-008 SHALL have port mem_addr, input, 32, byte address of the access.
REQ-009 SHALL have port store_data, input, 32, raw store operand, data in the low bits.
REQ-010 SHALL have port cache_stall, output, 1, global pipeline freeze.
REQ-011 SHALL have ports req_valid (output, 1), req_ready (input, 1), req_we (output, 1), req_addr (output, 32, word-aligned), req_wdata (output, 32), req_wstrb (output, 4): the memory request channel.
REQ-012 SHALL have ports resp_valid (input, 1) and resp_rdata (input, 32): the memory response channel.
REQ-013 SHALL have ports load_data (output, 32), load_valid (output, 1), misaligned (output, 1) and bus_error (output, 1).

Function
REQ-014 SHALL use a state machine with states IDLE, REQ, WAIT and DONE.
REQ-015 In IDLE, when (mem_read or mem_write) is high and the access is aligned, the block SHALL drive cache_stall high combinationally in that same cycle and enter REQ.
  - Alignment: half requires addr[0]=0; word requires addr[1:0]=0.
REQ-016 If mem_read and mem_write are both high, the block SHALL treat the access as a store.
REQ-017 For a misaligned access in IDLE, the block SHALL pulse misaligned for 1 cycle, issue no request, keep cache_stall low, and stay in IDLE.
REQ-018 cache_stall SHALL be high in REQ and WAIT, and low in DONE and in IDLE except as stated in REQ-015.
REQ-019 In REQ, req_valid SHALL be high with stable req_addr, req_we, req_wdata and req_wstrb.
  - On req_valid and req_ready high in the same cycle, the block SHALL go to WAIT.
  - req_valid SHALL never drop before the handshake completes.
REQ-020 req_addr SHALL be {mem_addr[31:2],2'b00}.
REQ-021 Store write strobes SHALL be:
  - byte: 4'b0001<<addr[1:0];
  - half: 4'b0011<<addr[1:0];
  - word: 4'b1111.
REQ-022 Store write data SHALL replicate the operand:
  - byte: store_data[7:0] replicated ×4;
  - half: store_data[15:0] replicated ×2;
  - word: as is.
REQ-023 For a load, req_wstrb SHALL be 4'b0000 and req_we SHALL be low.
REQ-024 The block SHALL latch the request fields when leaving IDLE.
  - Later input changes SHALL not affect the request in flight.
REQ-025 In WAIT, resp_valid SHALL move the block to DONE.
  - For a load, the block SHALL capture resp_rdata at that edge.
  - A store ack SHALL be resp_valid with rdata ignored.
REQ-026 In WAIT, a counter SHALL increment every cycle, starting from 0 on WAIT entry.
  - When the count reaches TIMEOUT_CYCLES without resp_valid, the block SHALL go to DONE with an error flag set.
  - If resp_valid arrives in the same cycle the count reaches TIMEOUT_CYCLES, the response SHALL win and no error is raised.
REQ-027 DONE SHALL last exactly 1 cycle, then return to IDLE; load_valid (loads only) or bus_error SHALL be high only during DONE.
REQ-028 load_data SHALL be formatted for a load as follows:
  - byte: lane addr[1:0] of resp_rdata, sign- or zero-extended;
  - half: lane addr[1], extended likewise;
  - word: unmodified.
  - On bus error, load_data SHALL be 0.
REQ-029 In IDLE, the block SHALL ignore resp_valid (a stray response).
REQ-030 In IDLE, DONE and WAIT, req_valid SHALL be low.
REQ-031 A new access SHALL be accepted no earlier than the IDLE cycle following DONE, giving a minimum of 4 cycles per access with zero-wait memory.

Reset
REQ-032 When rst is high at a clock edge, the block SHALL go to IDLE and clear the timeout counter and the latched request fields to 0.
  - This applies in any state, including reset mid-request or mid-wait, and abandons the outstanding request.
REQ-033 During and after reset, all outputs SHALL be 0 (cache_stall, req_valid, req_we, req_addr, req_wdata, req_wstrb, load_data, load_valid, misaligned, bus_error) until a new access is presented.

Verification
REQ-034 The bench SHALL cover a word load to 0x100 with ready and response both 1 cycle later.
  - Required response: cache_stall high for exactly 3 cycles, then DONE with load_valid=1 and load_data=resp_rdata.
REQ-035 The bench SHALL cover a signed byte load at 0x103 with resp_rdata=0x80FFFFFF.
  - Required response: load_data=0xFFFFFF80.
  - With mem_unsigned=1, required response: load_data=0x00000080.
REQ-036 The bench SHALL cover a half store at 0x202 with store_data=0x1234ABCD.
  - Required response: req_addr=0x200, req_wstrb=4'b1100, req_wdata=0xABCDABCD, req_we=1.
REQ-037 The bench SHALL cover a word load at 0x101.
  - Required response: misaligned pulses 1 cycle, req_valid never rises, cache_stall stays 0.
REQ-038 The bench SHALL cover TIMEOUT_CYCLES=4 with resp_valid held low.
  - Required response: bus_error for 1 cycle after 4 WAIT cycles, load_data=0, then IDLE.
  - Repeat with resp_valid on the 4th WAIT cycle; required response: no bus_error.
REQ-039 The bench SHALL cover rst asserted for 1 cycle while in WAIT.
  - Required response: next cycle IDLE, all outputs 0; a later resp_valid is ignored.

Source files
------------

// File: rtl/dmem_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_stall_ctrl
// Purpose  : Memory-stage data access controller. Turns a load/store from
//            the pipeline into a single request/response transaction on a
//            simple valid/ready memory bus. It freezes the pipeline while
//            the access is in flight, formats load data, and reports
//            misaligned accesses and response timeouts.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES : cycles spent waiting for a response before a bus error
//                    is raised (1..1023)
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   mem_read_i        : memory-stage instruction is a load
//   mem_write_i       : memory-stage instruction is a store (wins over read)
//   mem_size_i        : 00 byte, 01 half, 10/11 word
//   mem_unsigned_i    : zero-extend load data (sign-extend when low)
//   mem_addr_i        : byte address of the access
//   store_data_i      : store operand, data in the low bits
//   cache_stall_o     : global pipeline freeze
//   req_valid_o       : request valid, held until req_ready_i
//   req_ready_i       : memory accepts the request
//   req_we_o          : request is a write
//   req_addr_o        : word-aligned request address
//   req_wdata_o       : lane-replicated store data
//   req_wstrb_o       : byte write strobes (0 for loads)
//   resp_valid_i      : memory response / store acknowledge
//   resp_rdata_i      : response read data
//   load_data_o       : formatted load result, valid during the done cycle
//   load_valid_o      : load completed without error
//   misaligned_o      : one-cycle pulse for a rejected misaligned access
//   bus_error_o       : response timed out
// ============================================================================
module dmem_stall_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] store_data_i,
  output logic        cache_stall_o,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic        req_we_o,
  output logic [31:0] req_addr_o,
  output logic [31:0] req_wdata_o,
  output logic [3:0]  req_wstrb_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_rdata_i,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misaligned_o,
  output logic        bus_error_o
);

  // Last counter value of the wait window: the window lasts exactly
  // TIMEOUT_CYCLES cycles (count 0 .. TIMEOUT_CYCLES-1).
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;
  logic [31:0] ldata_q, ldata_d;

  // --------------------------------------------------------------------------
  // Access decoding helpers
  // --------------------------------------------------------------------------
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 1'b1;
      2'b01:   return ~off[0];
      default: return (off == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // The operand is replicated across all lanes so the strobes alone select
  // which bytes the memory actually writes.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   return {4{data[7:0]}};
      2'b01:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   return uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  logic w_access;
  logic w_aligned;

  assign w_access  = mem_read_i | mem_write_i;
  assign w_aligned = is_aligned(mem_size_i, mem_addr_i[1:0]);

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    err_d   = err_q;
    ldata_d = ldata_q;

    cache_stall_o = 1'b0;
    req_valid_o   = 1'b0;
    req_we_o      = we_q;
    req_addr_o    = addr_q;
    req_wdata_o   = wdata_q;
    req_wstrb_o   = wstrb_q;
    load_data_o   = 32'b0;
    load_valid_o  = 1'b0;
    misaligned_o  = 1'b0;
    bus_error_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Stray responses are ignored here simply by never looking at them.
        if (w_access) begin
          if (w_aligned) begin
            // Stall in the same cycle so the pipeline does not advance past
            // the access while its request is being latched.
            cache_stall_o = 1'b1;
            state_d       = S_REQ;
            we_d          = mem_write_i;
            addr_d        = {mem_addr_i[31:2], 2'b00};
            wdata_d       = mem_write_i ? store_lanes(mem_size_i, store_data_i) : 32'b0;
            wstrb_d       = mem_write_i ? store_strobe(mem_size_i, mem_addr_i[1:0]) : 4'b0000;
            size_d        = mem_size_i;
            uns_d         = mem_unsigned_i;
            off_d         = mem_addr_i[1:0];
            cnt_d         = 10'd0;
            err_d         = 1'b0;
            ldata_d       = 32'b0;
          end else begin
            misaligned_o = 1'b1;
          end
        end
      end

      S_REQ: begin
        cache_stall_o = 1'b1;
        req_valid_o   = 1'b1;
        if (req_ready_i) begin
          state_d = S_WAIT;
          cnt_d   = 10'd0;
        end
      end

      S_WAIT: begin
        cache_stall_o = 1'b1;
        // A response arriving in the last window cycle still wins over the
        // timeout because it is tested first.
        if (resp_valid_i) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          ldata_d = we_q ? 32'b0 : format_load(resp_rdata_i, size_q, off_q, uns_q);
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          ldata_d = 32'b0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      S_DONE: begin
        // New accesses are not looked at here; the earliest acceptance is
        // the following idle cycle.
        load_valid_o = ~we_q & ~err_q;
        bus_error_o  = err_q;
        load_data_o  = ldata_q;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Keep every output quiet while reset is asserted, even before the
    // registers have been cleared by the first reset edge.
    if (rst) begin
      cache_stall_o = 1'b0;
      req_valid_o   = 1'b0;
      req_we_o      = 1'b0;
      req_addr_o    = 32'b0;
      req_wdata_o   = 32'b0;
      req_wstrb_o   = 4'b0;
      load_data_o   = 32'b0;
      load_valid_o  = 1'b0;
      misaligned_o  = 1'b0;
      bus_error_o   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 10'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      wstrb_q <= 4'b0;
      size_q  <= 2'b0;
      uns_q   <= 1'b0;
      off_q   <= 2'b0;
      err_q   <= 1'b0;
      ldata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      err_q   <= err_d;
      ldata_q <= ldata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_stall_ctrl
// Purpose  : Self-checking bench for dmem_stall_ctrl. Each access is
//            predicted cycle by cycle from the access rules (alignment,
//            strobes, lane replication, load extension, timeout window).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_stall_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, store_data;
  logic        cache_stall, req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata, load_data;
  logic        load_valid, misaligned, bus_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_stall_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_i    (mem_read),
    .mem_write_i   (mem_write),
    .mem_size_i    (mem_size),
    .mem_unsigned_i(mem_unsigned),
    .mem_addr_i    (mem_addr),
    .store_data_i  (store_data),
    .cache_stall_o (cache_stall),
    .req_valid_o   (req_valid),
    .req_ready_i   (req_ready),
    .req_we_o      (req_we),
    .req_addr_o    (req_addr),
    .req_wdata_o   (req_wdata),
    .req_wstrb_o   (req_wstrb),
    .resp_valid_i  (resp_valid),
    .resp_rdata_i  (resp_rdata),
    .load_data_o   (load_data),
    .load_valid_o  (load_valid),
    .misaligned_o  (misaligned),
    .bus_error_o   (bus_error)
  );

  // ---------------- reference model (arithmetic form of the rules) --------
  function automatic logic m_aligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
    int sh;
    sh = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << sh);
    if (sz == 2'd1) return 4'(3 << sh);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // {cache_stall, req_valid, load_valid, bus_error, misaligned}
  function automatic logic [4:0] flags();
    return {cache_stall, req_valid, load_valid, bus_error, misaligned};
  endfunction

  function automatic logic [105:0] all_out();
    return {cache_stall, req_valid, req_we, req_addr, req_wdata, req_wstrb,
            load_data, load_valid, misaligned, bus_error};
  endfunction

  // ---------------- stimulus helpers --------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = 2'd0;
    mem_unsigned = 1'b0;
    mem_addr     = 32'd0;
    store_data   = 32'd0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = 32'd0;
  endtask

  // No access requested, but every other access input changes, so a request
  // in flight that failed to latch its fields would show it.
  task automatic scramble();
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_size     = 2'($urandom_range(0, 3));
    mem_unsigned = 1'($urandom_range(0, 1));
    mem_addr     = $urandom;
    store_data   = $urandom;
  endtask

  // One complete access predicted from the rules. rdy_dly = REQ cycles
  // before ready; rsp_dly = 0-based WAIT cycle carrying the response
  // (>= TO means no response at all). trail adds an idle cycle with a stray
  // response afterwards.
  task automatic do_access(input logic wr, input logic rd, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] rdata,
                           input int rdy_dly, input int rsp_dly, input bit trail,
                           input string tag, output int stall_cnt);
    logic        al, err;
    logic [4:0]  ef;
    logic [31:0] eld;
    logic [36:0] efld;
    int          nwait;
    al        = m_aligned(sz, addr);
    err       = (rsp_dly >= TO);
    stall_cnt = 0;

    tick();
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    mem_addr = addr; store_data = sd;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = $urandom;
    #1;
    ef = {al, 1'b0, 1'b0, 1'b0, ~al};
    total++;
    if (flags() !== ef) begin
      bad++;
      $display("FAIL %s present: flags=%b expected=%b", tag, flags(), ef);
    end
    if (cache_stall) stall_cnt++;

    if (!al) begin
      for (int k = 0; k < 2; k++) begin
        tick();
        idle_inputs();
        #1;
        total++;
        if (flags() !== 5'b00000) begin
          bad++;
          $display("FAIL %s after_misaligned: flags=%b expected=00000", tag, flags());
        end
      end
      return;
    end

    efld = {wr, addr & ~32'h3, wr ? m_strb(sz, addr) : 4'h0};
    for (int i = 0; i <= rdy_dly; i++) begin
      tick();
      scramble();
      req_ready = (i == rdy_dly);
      #1;
      total++;
      if (flags() !== 5'b11000) begin
        bad++;
        $display("FAIL %s req_flags: flags=%b expected=11000", tag, flags());
      end
      total++;
      if ({req_we, req_addr, req_wstrb} !== efld) begin
        bad++;
        $display("FAIL %s req_fields: we/addr/strb=%b/%h/%b expected=%b/%h/%b", tag,
                 req_we, req_addr, req_wstrb, efld[36], efld[35:4], efld[3:0]);
      end
      if (wr) begin
        total++;
        if (req_wdata !== m_wdata(sz, sd)) begin
          bad++;
          $display("FAIL %s req_wdata: got=%h expected=%h", tag, req_wdata, m_wdata(sz, sd));
        end
      end
      if (cache_stall) stall_cnt++;
    end

    nwait = err ? TO : rsp_dly + 1;
    for (int j = 0; j < nwait; j++) begin
      tick();
      scramble();
      req_ready  = 1'($urandom_range(0, 1));
      resp_valid = (j == rsp_dly);
      resp_rdata = (j == rsp_dly) ? rdata : $urandom;
      #1;
      total++;
      if (flags() !== 5'b10000) begin
        bad++;
        $display("FAIL %s wait_flags: cycle=%0d flags=%b expected=10000", tag, j, flags());
      end
      if (cache_stall) stall_cnt++;
    end

    // Done cycle: an aligned access is offered here and must not be taken.
    tick();
    scramble();
    mem_read   = 1'($urandom_range(0, 1));
    mem_addr   = $urandom & ~32'h3;
    mem_size   = 2'd2;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = $urandom;
    #1;
    ef = {1'b0, 1'b0, ~wr & ~err, err, 1'b0};
    total++;
    if (flags() !== ef) begin
      bad++;
      $display("FAIL %s done_flags: flags=%b expected=%b", tag, flags(), ef);
    end
    if (!wr || err) begin
      eld = err ? 32'd0 : m_load(sz, uns, addr, rdata);
      total++;
      if (load_data !== eld) begin
        bad++;
        $display("FAIL %s load_data: got=%h expected=%h", tag, load_data, eld);
      end
    end

    if (trail) begin
      tick();
      idle_inputs();
      resp_valid = 1'($urandom_range(0, 1));
      resp_rdata = $urandom;
      #1;
      total++;
      if (flags() !== 5'b00000) begin
        bad++;
        $display("FAIL %s idle_after: flags=%b expected=00000", tag, flags());
      end
    end
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    mem_read = 1'b1; mem_size = 2'd2; mem_addr = 32'h100;
    tick();
    tick();
    total++;
    if (all_out() !== '0) begin
      bad++;
      $display("FAIL reset_hold: outputs=%h expected=0", all_out());
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    total++;
    if (all_out() !== '0) begin
      bad++;
      $display("FAIL reset_release: outputs=%h expected=0", all_out());
    end
  endtask

  task automatic test_word_load();
    int sc;
    do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'd0, 32'hCAFE_1234, 0, 0, 1'b1, "word_load", sc);
    total++;
    if (sc !== 3) begin
      bad++;
      $display("FAIL word_load_stall_cycles: got=%0d expected=3", sc);
    end
  endtask

  task automatic test_byte_load();
    int sc;
    do_access(1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'd0, 32'h80FF_FFFF, 0, 0, 1'b1, "byte_load_signed", sc);
    do_access(1'b0, 1'b1, 2'd0, 1'b1, 32'h103, 32'd0, 32'h80FF_FFFF, 0, 0, 1'b1, "byte_load_unsigned", sc);
    do_access(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'd0, 32'h9234_5678, 1, 1, 1'b1, "half_load_signed", sc);
  endtask

  task automatic test_half_store();
    int sc;
    do_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0, 1'b1, "half_store", sc);
    // Read and write together behave as a store.
    do_access(1'b1, 1'b1, 2'd0, 1'b0, 32'h301, 32'h0000_005A, 32'h1111_1111, 0, 0, 1'b1, "rw_is_store", sc);
  endtask

  task automatic test_misaligned();
    int sc;
    do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h101, 32'd0, 32'd0, 0, 0, 1'b0, "misaligned_word", sc);
    do_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h203, 32'h1234, 32'd0, 0, 0, 1'b0, "misaligned_half", sc);
    do_access(1'b0, 1'b1, 2'd3, 1'b0, 32'h102, 32'd0, 32'd0, 0, 0, 1'b0, "misaligned_rsvd", sc);
  endtask

  task automatic test_timeout();
    int sc;
    do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'd0, 32'h1234_5678, 0, 1000, 1'b1, "timeout_load", sc);
    total++;
    if (sc !== 2 + TO) begin
      bad++;
      $display("FAIL timeout_stall_cycles: got=%0d expected=%0d", sc, 2 + TO);
    end
    do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'd0, 32'h8765_4321, 0, TO - 1, 1'b1, "last_cycle_resp", sc);
    do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h404, 32'hDEAD_BEEF, 32'd0, 2, 1000, 1'b1, "timeout_store", sc);
  endtask

  task automatic test_reset_mid_wait();
    int sc;
    tick();
    idle_inputs();
    mem_read = 1'b1; mem_size = 2'd2; mem_addr = 32'h40;
    tick();
    idle_inputs();
    req_ready = 1'b1;
    tick();
    idle_inputs();
    #1;
    total++;
    if (flags() !== 5'b10000) begin
      bad++;
      $display("FAIL rst_wait_entry: flags=%b expected=10000", flags());
    end
    rst = 1'b1;
    #1;
    total++;
    if (all_out() !== '0) begin
      bad++;
      $display("FAIL rst_wait_during: outputs=%h expected=0", all_out());
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      rst        = 1'b0;
      resp_valid = 1'b1;
      resp_rdata = $urandom;
      #1;
      total++;
      if (all_out() !== '0) begin
        bad++;
        $display("FAIL rst_wait_after: cycle=%0d outputs=%h expected=0", k, all_out());
      end
    end
    do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h44, 32'd0, 32'h0BAD_F00D, 0, 0, 1'b1, "after_reset", sc);
  endtask

  task automatic test_back_to_back();
    int sc;
    do_access(1'b0, 1'b1, 2'd2, 1'b0, 32'h500, 32'd0, $urandom, 0, 0, 1'b0, "b2b_0", sc);
    do_access(1'b1, 1'b0, 2'd0, 1'b0, 32'h502, $urandom, 32'd0, 0, 0, 1'b0, "b2b_1", sc);
    do_access(1'b0, 1'b1, 2'd1, 1'b1, 32'h506, 32'd0, $urandom, 0, 0, 1'b0, "b2b_2", sc);
    do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h508, $urandom, 32'd0, 0, 0, 1'b1, "b2b_3", sc);
  endtask

  task automatic test_random();
    int   sc;
    logic wr, rd;
    for (int n = 0; n < 80; n++) begin
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (!wr && !rd) rd = 1'b1;
      do_access(wr, rd, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, TO + 1),
                1'($urandom_range(0, 1)), "random", sc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
